axi_rd_arb: RTL and testbench
=============================

// Module: axi_rd_arb
// PURPOSE
//  Shares the core's single AXI4 read master (AR/R channels) between NRQ read requesters:
//  icache refill, dcache refill, page-table walker and uncached/MMIO load.
//  - AR side: round-robin arbitration behind a registered AR stage; the requester index is
//    tagged into arid.
//  - R side: beats are routed back by rid; outstanding bursts are tracked per requester.
//  Sits between the MMU/cache subsystem and the m_axi_* read ports of the core top.
// PARAMETERS
//  NRQ    4  number of requesters (2..8)
//  IDW    4  requester-local ID width; $clog2(NRQ)+IDW <= 8 (elaboration assertion)
//  MAXOUT 4  max outstanding bursts per requester (1..15)
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous reset, active-high
//  rq_arvalid     in   NRQ         per-requester read request valid
//  rq_arready     out  NRQ         per-requester request accepted
//  rq_araddr      in   NRQ x 64    request address
//  rq_arlen       in   NRQ x 8     burst length - 1
//  rq_arsize      in   NRQ x 3     beat size (log2 bytes)
//  rq_arid        in   NRQ x IDW   requester-local ID
//  rq_rvalid      out  NRQ         read beat valid, one-hot or zero
//  rq_rready      in   NRQ         requester accepts beat
//  rq_rdata       out  64          read data, shared by all requesters
//  rq_rid         out  IDW         local ID of the current beat
//  rq_rresp       out  2           beat response
//  rq_rlast       out  1           last beat of burst
//  m_axi_ar*      out  AXI4        arid 8, araddr 64, arlen 8, arsize 3, arburst 2, arlock 1,
//                                  arcache 4, arprot 3, arqos 4, arvalid 1
//  m_axi_arready  in   1           slave accepts AR
//  m_axi_r*       in   AXI4        rid 8, rdata 64, rresp 2, rlast 1, rvalid 1
//  m_axi_rready   out  1           master accepts R beat
//  rid_err        out  1           sticky: an R beat carried an out-of-range requester index
// BEHAVIOUR
//  - Reset: m_axi_arvalid=0; all outstanding counters=0; RR pointer=0; rid_err=0.
//    rq_arready=0 during reset.
//  - AR stage is one register, state IDLE/BUSY:
//    - IDLE: eligible requester i = rq_arvalid[i] & (cnt[i] < MAXOUT).
//      Grant the first eligible index at or after ptr, wrapping modulo NRQ.
//      rq_arready[grant]=1 in the same cycle; the request is latched; next state BUSY; ptr <= grant+1 (mod NRQ).
//    - BUSY: m_axi_arvalid=1 and all AR fields held stable.
//      On m_axi_arready: -> IDLE. Back-to-back issue is allowed: the same cycle may also
//      accept the next grant, for 1 AR per cycle sustained.
//  - Latency: rq_arvalid/rq_arready handshake to m_axi_arvalid is 1 cycle.
//  - arid = {grant index, rq_arid}, zero-extended to 8 bits.
//    Constant fields: arburst=2'b01 (INCR), arlock=0, arcache=4'b0011, arprot=0, arqos=0.
//  - cnt[i] increments on grant to i.
//  - R path is combinational, zero latency:
//    - sel = rid[IDW+:$clog2(NRQ)]; rq_rvalid[sel]=m_axi_rvalid; m_axi_rready=rq_rready[sel].
//    - rq_rid = rid[IDW-1:0].
//  - cnt[sel] decrements on an R handshake with rlast.
//    A grant and an rlast handshake to the same requester in one cycle leave cnt unchanged.
//  - Out-of-range sel (>= NRQ): the beat is consumed with m_axi_rready=1, no rq_rvalid is
//    asserted, and rid_err is set; rid_err clears only on rst.
//  - A requester at cnt==MAXOUT is skipped without moving ptr past it; other requesters proceed.
//  - Reset mid-burst discards all state. Requesters and the slave are reset by the same rst,
//    so no in-flight beats survive.
//  - Assertion: R handshake with rlast while cnt[sel]==0 is a bench error.
// CONFIGURATION
//  AXI_RD_ARB_PERF_EN
//   - Defined: adds outputs perf_grant[NRQ] (64b each) and perf_stall[NRQ] (64b each).
//     - perf_grant counts grants.
//     - perf_stall counts cycles with rq_arvalid=1 and rq_arready=0.
//     - Both are cleared on rst and wrap at 2^64.
//   - Undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  - Single request: rq0 addr 0x80001000, len 7, id 3.
//    -> next cycle arid=0x03, araddr=0x80001000, arlen=7.
//    -> 8 R beats with rid=0x03 appear only on rq_rvalid[0]; cnt0 goes 0->1->0.
//  - All four requesters valid, arready=1 constantly.
//    -> grants in order 0,1,2,3,0; arid upper bits 0,1,2,3,0 on consecutive cycles.
//  - arready held 0 for 5 cycles.
//    -> arvalid and all AR fields stable for the 5 cycles; no second grant until the handshake.
//  - rq1 issues MAXOUT=4 requests with no R.
//    -> 5th request stalls (rq_arready[1]=0) while rq2 is still granted.
//    -> after rq1 receives an rlast, the next rq1 grant happens within 1 cycle.
//  - R beat with rid=0x70 and NRQ=4.
//    -> m_axi_rready=1, rq_rvalid=0, rid_err=1 and held until rst.
//  - rst asserted mid-burst with cnt0=2.
//    -> next cycle arvalid=0, cnt=0, ptr=0, rid_err=0.
//    -> PERF counters =0 (with AXI_RD_ARB_PERF_EN).

Source files
------------

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: round-robin arbiter sharing one AXI4 read master (AR/R) among NRQ requesters.
// Optional build macro AXI_RD_ARB_PERF_EN adds per-requester grant/stall counters.
module axi_rd_arb #(
    parameter int NRQ    = 4,
    parameter int IDW    = 4,
    parameter int MAXOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NRQ-1:0]     rq_arvalid,
    output logic [NRQ-1:0]     rq_arready,
    input  logic [NRQ*64-1:0]  rq_araddr,
    input  logic [NRQ*8-1:0]   rq_arlen,
    input  logic [NRQ*3-1:0]   rq_arsize,
    input  logic [NRQ*IDW-1:0] rq_arid,
    output logic [NRQ-1:0]     rq_rvalid,
    input  logic [NRQ-1:0]     rq_rready,
    output logic [63:0]        rq_rdata,
    output logic [IDW-1:0]     rq_rid,
    output logic [1:0]         rq_rresp,
    output logic               rq_rlast,
    output logic [7:0]         m_axi_arid,
    output logic [63:0]        m_axi_araddr,
    output logic [7:0]         m_axi_arlen,
    output logic [2:0]         m_axi_arsize,
    output logic [1:0]         m_axi_arburst,
    output logic               m_axi_arlock,
    output logic [3:0]         m_axi_arcache,
    output logic [2:0]         m_axi_arprot,
    output logic [3:0]         m_axi_arqos,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    input  logic [7:0]         m_axi_rid,
    input  logic [63:0]        m_axi_rdata,
    input  logic [1:0]         m_axi_rresp,
    input  logic               m_axi_rlast,
    input  logic               m_axi_rvalid,
    output logic               m_axi_rready,
    output logic               rid_err
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [NRQ*64-1:0]  perf_grant,
    output logic [NRQ*64-1:0]  perf_stall
`endif
);
    localparam int SW = $clog2(NRQ);
    localparam int UW = 8 - IDW;
    localparam int CW = 4;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    if (SW + IDW > 8) begin : g_idw_chk
        $error("axi_rd_arb: $clog2(NRQ)+IDW exceeds the 8-bit arid");
    end

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [7:0]    arid_q, arid_d;
    logic [63:0]   araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic [2:0]    arsize_q, arsize_d;
    logic          rid_err_q, rid_err_d;
    logic [CW-1:0] cnt_q [NRQ];
    logic [CW-1:0] cnt_d [NRQ];

    logic [NRQ-1:0] elig_s;
    logic           gnt_vld_s;
    logic [SW-1:0]  gnt_idx_s;
    logic [SW:0]    scan_s;
    logic           fire_s;
    logic [UW-1:0]  rsel_full_s;
    logic           rsel_ok_s;
    logic [SW-1:0]  rsel_s;
    logic [NRQ-1:0] dec_s;

    // A requester may compete only while it has room for another outstanding burst
    always_comb begin
        for (int i = 0; i < NRQ; i++) begin
            elig_s[i] = rq_arvalid[i] && (cnt_q[i] < CW'(MAXOUT));
        end
    end

    // Round-robin scan: first eligible index at or after ptr, wrapping
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        scan_s    = '0;
        for (int k = 0; k < NRQ; k++) begin
            scan_s = {1'b0, ptr_q} + (SW+1)'(k);
            if (scan_s >= (SW+1)'(NRQ)) begin
                scan_s = scan_s - (SW+1)'(NRQ);
            end else begin
                scan_s = scan_s;
            end
            if (!gnt_vld_s && elig_s[scan_s[SW-1:0]]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = scan_s[SW-1:0];
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // The AR register can take a new request when empty or draining this cycle
    always_comb begin
        fire_s     = gnt_vld_s && !rst && ((state_q == ST_IDLE) || m_axi_arready);
        rq_arready = '0;
        if (fire_s) begin
            rq_arready[gnt_idx_s] = 1'b1;
        end else begin
            rq_arready = '0;
        end
    end

    // AR stage next state and latched request fields
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        arid_d   = arid_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arsize_d = arsize_q;
        if (fire_s) begin
            state_d  = ST_BUSY;
            ptr_d    = (gnt_idx_s == SW'(NRQ-1)) ? '0 : gnt_idx_s + SW'(1);
            arid_d   = '0;
            arid_d[IDW-1:0]  = rq_arid[int'(gnt_idx_s)*IDW +: IDW];
            arid_d[IDW +: SW] = gnt_idx_s;
            araddr_d = rq_araddr[int'(gnt_idx_s)*64 +: 64];
            arlen_d  = rq_arlen[int'(gnt_idx_s)*8 +: 8];
            arsize_d = rq_arsize[int'(gnt_idx_s)*3 +: 3];
        end else if (m_axi_arready) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // R routing by the requester index carried in the upper rid bits
    always_comb begin
        rsel_full_s  = m_axi_rid[7:IDW];
        rsel_ok_s    = ({{(32-UW){1'b0}}, rsel_full_s} < 32'(NRQ));
        rsel_s       = rsel_full_s[SW-1:0];
        rq_rvalid    = '0;
        m_axi_rready = 1'b1;
        dec_s        = '0;
        if (rsel_ok_s) begin
            rq_rvalid[rsel_s] = m_axi_rvalid;
            m_axi_rready      = rq_rready[rsel_s];
            dec_s[rsel_s]     = m_axi_rvalid && rq_rready[rsel_s] && m_axi_rlast;
        end else begin
            rq_rvalid    = '0;
            m_axi_rready = 1'b1;
            dec_s        = '0;
        end
        rid_err_d = rid_err_q || (m_axi_rvalid && !rsel_ok_s);
    end

    // Outstanding burst counters: grant adds one, rlast handshake removes one
    always_comb begin
        for (int i = 0; i < NRQ; i++) begin
            if (rq_arready[i] && !dec_s[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!rq_arready[i] && dec_s[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            rid_err_q <= 1'b0;
            for (int i = 0; i < NRQ; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            rid_err_q <= rid_err_d;
            for (int i = 0; i < NRQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign m_axi_arvalid = state_q[0];
    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign rq_rdata      = m_axi_rdata;
    assign rq_rid        = m_axi_rid[IDW-1:0];
    assign rq_rresp      = m_axi_rresp;
    assign rq_rlast      = m_axi_rlast;
    assign rid_err       = rid_err_q;

`ifdef AXI_RD_ARB_PERF_EN
    logic [63:0] perf_grant_q [NRQ];
    logic [63:0] perf_stall_q [NRQ];

    // Free-running per-requester grant and stall counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < NRQ; i++) begin
            if (rst) begin
                perf_grant_q[i] <= 64'd0;
                perf_stall_q[i] <= 64'd0;
            end else begin
                perf_grant_q[i] <= perf_grant_q[i] + {63'd0, rq_arready[i]};
                perf_stall_q[i] <= perf_stall_q[i] + {63'd0, rq_arvalid[i] && !rq_arready[i]};
            end
        end
    end

    // Flatten counters onto the output buses
    always_comb begin
        for (int i = 0; i < NRQ; i++) begin
            perf_grant[i*64 +: 64] = perf_grant_q[i];
            perf_stall[i*64 +: 64] = perf_stall_q[i];
        end
    end
`endif
endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed self-checking bench for axi_rd_arb (NRQ=4, IDW=4, MAXOUT=4).
module tb_axi_rd_arb;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rq_arvalid, rq_arready, rq_rvalid, rq_rready;
    logic [255:0] rq_araddr;
    logic [31:0]  rq_arlen;
    logic [11:0]  rq_arsize;
    logic [15:0]  rq_arid;
    logic [63:0]  rq_rdata;
    logic [3:0]   rq_rid;
    logic [1:0]   rq_rresp;
    logic         rq_rlast;
    logic [7:0]   m_axi_arid, m_axi_arlen;
    logic [63:0]  m_axi_araddr;
    logic [2:0]   m_axi_arsize, m_axi_arprot;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [3:0]   m_axi_arcache, m_axi_arqos;
    logic [7:0]   m_axi_rid;
    logic [63:0]  m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic         rid_err;
`ifdef AXI_RD_ARB_PERF_EN
    logic [255:0] perf_grant, perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] mon_sel;

    always #5 clk = ~clk;

    axi_rd_arb #(.NRQ(4), .IDW(4), .MAXOUT(4)) dut (
        .clk(clk), .rst(rst),
        .rq_arvalid(rq_arvalid), .rq_arready(rq_arready), .rq_araddr(rq_araddr),
        .rq_arlen(rq_arlen), .rq_arsize(rq_arsize), .rq_arid(rq_arid),
        .rq_rvalid(rq_rvalid), .rq_rready(rq_rready), .rq_rdata(rq_rdata),
        .rq_rid(rq_rid), .rq_rresp(rq_rresp), .rq_rlast(rq_rlast),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .rid_err(rid_err)
`ifdef AXI_RD_ARB_PERF_EN
        , .perf_grant(perf_grant), .perf_stall(perf_stall)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [3:0] id);
        rq_araddr[i*64 +: 64] = addr;
        rq_arlen[i*8 +: 8]    = len;
        rq_arsize[i*3 +: 3]   = size;
        rq_arid[i*4 +: 4]     = id;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // An rlast handshake must never arrive for a requester with nothing outstanding
    always @(negedge clk) begin
        if (!rst && m_axi_rvalid && m_axi_rready && m_axi_rlast && m_axi_rid[7:4] < 4'd4) begin
            mon_sel = m_axi_rid[5:4];
            check_eq("rlast_with_cnt0", 64'(dut.cnt_q[mon_sel] == 4'd0), 64'd0);
        end
    end

    initial begin
        rst = 1'b1;
        rq_arvalid = '0; rq_rready = '0; rq_araddr = '0; rq_arlen = '0;
        rq_arsize = '0; rq_arid = '0; m_axi_arready = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

        // Reset state, with a request pending during reset
        rq_arvalid = 4'b0001;
        cyc(); cyc();
        check_eq("rst_arready", 64'(rq_arready), 64'h0);
        check_eq("rst_arvalid", 64'(m_axi_arvalid), 64'h0);
        check_eq("rst_rid_err", 64'(rid_err), 64'h0);
        check_eq("rst_cnt0", 64'(dut.cnt_q[0]), 64'h0);
        rst = 1'b0;
        rq_arvalid = '0;

        // Single request from rq0
        set_rq(0, 64'h8000_1000, 8'd7, 3'd3, 4'h3);
        rq_arvalid = 4'b0001;
        m_axi_arready = 1'b1;
        #1 check_eq("single_grant", 64'(rq_arready), 64'h1);
        cyc();
        rq_arvalid = '0;
        check_eq("single_arvalid", 64'(m_axi_arvalid), 64'h1);
        check_eq("single_arid", 64'(m_axi_arid), 64'h03);
        check_eq("single_araddr", m_axi_araddr, 64'h8000_1000);
        check_eq("single_arlen", 64'(m_axi_arlen), 64'h7);
        check_eq("single_arsize", 64'(m_axi_arsize), 64'h3);
        check_eq("const_fields", 64'({m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos}),
                 64'(14'b01_0_0011_000_0000));
        check_eq("single_cnt0_up", 64'(dut.cnt_q[0]), 64'h1);
        cyc();
        check_eq("single_ar_done", 64'(m_axi_arvalid), 64'h0);
        // Backpressure from requester reaches the slave
        m_axi_rvalid = 1'b1; m_axi_rid = 8'h03; rq_rready = 4'b0000;
        #1 check_eq("r_backpressure", 64'(m_axi_rready), 64'h0);
        rq_rready = 4'b0001;
        for (int b = 0; b < 8; b++) begin
            m_axi_rdata = 64'hA5A5_0000_0000_0000 + 64'(b);
            m_axi_rlast = (b == 7);
            #1;
            check_eq("r_route_valid", 64'(rq_rvalid), 64'h1);
            check_eq("r_route_ready", 64'(m_axi_rready), 64'h1);
            check_eq("r_data", rq_rdata, 64'hA5A5_0000_0000_0000 + 64'(b));
            check_eq("r_rid", 64'(rq_rid), 64'h3);
            check_eq("r_cnt0_held", 64'(dut.cnt_q[0]), 64'h1);
            cyc();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; rq_rready = '0;
        check_eq("single_cnt0_down", 64'(dut.cnt_q[0]), 64'h0);

        // Round robin with all four requesters, slave always ready
        do_reset();
        for (int i = 0; i < 4; i++) set_rq(i, 64'h1000 * 64'(i + 1), 8'd0, 3'd3, 4'(i + 8));
        rq_arvalid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 check_eq("rr_grant", 64'(rq_arready), 64'(4'b0001 << (k % 4)));
            cyc();
            check_eq("rr_arid_hi", 64'(m_axi_arid[7:4]), 64'(k % 4));
            check_eq("rr_arvalid", 64'(m_axi_arvalid), 64'h1);
        end
        rq_arvalid = '0;
        check_eq("rr_cnt0", 64'(dut.cnt_q[0]), 64'h2);
        cyc();

        // Out-of-range requester index in rid
        m_axi_rvalid = 1'b1; m_axi_rid = 8'h70; m_axi_rlast = 1'b1; rq_rready = 4'b0000;
        #1;
        check_eq("oor_rready", 64'(m_axi_rready), 64'h1);
        check_eq("oor_rvalid", 64'(rq_rvalid), 64'h0);
        cyc();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        check_eq("oor_rid_err", 64'(rid_err), 64'h1);
        cyc(); cyc();
        check_eq("oor_rid_err_sticky", 64'(rid_err), 64'h1);

        // Reset mid-burst: rq0 has two bursts outstanding, one beat in flight, AR pending
        m_axi_rvalid = 1'b1; m_axi_rid = 8'h09; rq_rready = 4'b0001;
        m_axi_arready = 1'b0; rq_arvalid = 4'b0100;
        cyc();
        m_axi_rvalid = 1'b0; rq_arvalid = '0; rq_rready = '0;
        check_eq("mid_cnt0", 64'(dut.cnt_q[0]), 64'h2);
        check_eq("mid_arvalid", 64'(m_axi_arvalid), 64'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("rst2_arvalid", 64'(m_axi_arvalid), 64'h0);
        check_eq("rst2_cnt", 64'({dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2], dut.cnt_q[3]}), 64'h0);
        check_eq("rst2_ptr", 64'(dut.ptr_q), 64'h0);
        check_eq("rst2_rid_err", 64'(rid_err), 64'h0);
`ifdef AXI_RD_ARB_PERF_EN
        check_eq("rst2_perf", 64'(|{perf_grant, perf_stall}), 64'h0);
`endif

        // Slave stalls for 5 cycles: AR held, no further grant
        set_rq(0, 64'h0000_0000_4000_0040, 8'd3, 3'd3, 4'h5);
        set_rq(1, 64'h0000_0000_2000_2000, 8'd1, 3'd2, 4'hA);
        m_axi_arready = 1'b0;
        rq_arvalid = 4'b0011;
        #1 check_eq("hold_grant0", 64'(rq_arready), 64'h1);
        cyc();
        rq_arvalid = 4'b0010;
        set_rq(0, 64'hDEAD_BEEF_0000_0000, 8'd9, 3'd1, 4'h1);
        for (int k = 0; k < 5; k++) begin
            check_eq("hold_arvalid", 64'(m_axi_arvalid), 64'h1);
            check_eq("hold_fields", {m_axi_araddr[47:0], m_axi_arid, m_axi_arlen},
                     {48'h0000_4000_0040, 8'h05, 8'h03});
            check_eq("hold_no_grant", 64'(rq_arready), 64'h0);
            cyc();
        end
        m_axi_arready = 1'b1;
        #1 check_eq("b2b_grant1", 64'(rq_arready), 64'h2);
        cyc();
        rq_arvalid = '0;
        check_eq("b2b_arid", 64'(m_axi_arid), 64'h1A);
        check_eq("b2b_araddr", m_axi_araddr, 64'h2000_2000);
        cyc();

        // rq1 fills its outstanding budget, rq2 still served
        do_reset();
        rq_arvalid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1 check_eq("max_fill_grant", 64'(rq_arready), 64'h2);
            cyc();
        end
        rq_arvalid = 4'b0110;
        #1 check_eq("max_rq2_granted", 64'(rq_arready), 64'h4);
        cyc();
        rq_arvalid = 4'b0010;
        #1;
        check_eq("max_rq1_stalled", 64'(rq_arready), 64'h0);
        check_eq("max_cnt1", 64'(dut.cnt_q[1]), 64'h4);
        m_axi_rvalid = 1'b1; m_axi_rid = 8'h10; m_axi_rlast = 1'b1; rq_rready = 4'b0010;
        #1;
        check_eq("max_r_route", 64'(rq_rvalid), 64'h2);
        check_eq("max_still_stalled", 64'(rq_arready), 64'h0);
        cyc();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; rq_rready = '0;
        #1 check_eq("max_regrant", 64'(rq_arready), 64'h2);
        cyc();
        rq_arvalid = '0;
        check_eq("max_cnt1_again", 64'(dut.cnt_q[1]), 64'h4);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
